// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32I funct3 widths and fault codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_ILLEGAL  = 2'd2,
    FLT_TIMEOUT  = 2'd3
  } lsu_fault_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

endpackage

// File: rtl/lsu_if.sv
// Handshaked data-memory bus between the load/store unit (master) and the memory (slave).
interface lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, be, addr, wdata, input  ready, rvalid, rdata);
  modport slave  (input  req, we, be, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: request decode (byte enables, store replication, fault checks)
// and load-data shift/extension from the captured access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[7:0];
    h = word[15:0];
    case (f3)
      F3_LB:   r = 32'(b);
      F3_LH:   r = 32'(h);
      F3_LW:   r = word;
      F3_LBU:  r = {24'd0, word[7:0]};
      F3_LHU:  r = {16'd0, word[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    be    = 4'hF;
    wdata = req_wdata;
    case (req_funct3[1:0])
      F3_SB[1:0]: begin
        be    = 4'b0001 << req_off;
        wdata = {4{req_wdata[7:0]}};
      end
      F3_SH[1:0]: begin
        be    = 4'b0011 << req_off;
        wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign illegal    = req_write ? (req_funct3 > F3_SW)
                                : !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  assign misaligned = ((req_funct3[1:0] == F3_LH[1:0]) && req_off[0]) ||
                      ((req_funct3[1:0] == F3_LW[1:0]) && (req_off != 2'd0));

  assign ld_data = extend(ld_word >> {ld_off, 3'b000}, ld_funct3);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: captures a core request, runs one handshaked memory
// access (or faults it locally), and stalls the core until the single-cycle done pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  lsu_if.master       mem
);

  lsu_state_e  state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        expired;
  logic        write_p0;
  logic [2:0]  f3_p0;
  logic [1:0]  off_p0;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] ld_data;
  logic        misaligned;
  logic        illegal;

  lsu_align u_align (
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_off    (req_addr[1:0]),
    .req_wdata  (req_wdata),
    .be         (be_w),
    .wdata      (wdata_w),
    .misaligned (misaligned),
    .illegal    (illegal),
    .ld_funct3  (f3_p0),
    .ld_off     (off_p0),
    .ld_word    (mem.rdata),
    .ld_data    (ld_data)
  );

  assign cnt_nxt = cnt + 8'd1;
  assign expired = (cnt_nxt == 8'(TIMEOUT));
  assign stall   = (state == ST_REQ) || (state == ST_RESP) || ((state == ST_IDLE) && req_valid);
  assign done    = (state == ST_DONE);
  assign mem.req = (state == ST_REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rdata     <= '0;
      fault     <= FLT_NONE;
      write_p0  <= 1'b0;
      f3_p0     <= '0;
      off_p0    <= '0;
      mem.we    <= 1'b0;
      mem.be    <= '0;
      mem.addr  <= '0;
      mem.wdata <= '0;
    end else begin
      case (state)
        // Capture: faults complete locally without touching the bus
        ST_IDLE: if (req_valid) begin
          write_p0 <= req_write;
          f3_p0    <= req_funct3;
          off_p0   <= req_addr[1:0];
          rdata    <= '0;
          if (illegal) begin
            fault <= FLT_ILLEGAL;
            state <= ST_DONE;
          end else if (misaligned) begin
            fault <= FLT_MISALIGN;
            state <= ST_DONE;
          end else begin
            fault     <= FLT_NONE;
            cnt       <= '0;
            mem.we    <= req_write;
            mem.be    <= be_w;
            mem.addr  <= {req_addr[31:2], 2'b00};
            mem.wdata <= wdata_w;
            state     <= ST_REQ;
          end
        end
        // Address phase; a zero-wait read may complete here, and completion beats timeout
        ST_REQ: begin
          cnt <= cnt_nxt;
          if (mem.ready && (write_p0 || mem.rvalid)) begin
            if (!write_p0) rdata <= ld_data;
            state <= ST_DONE;
          end else if (expired) begin
            fault <= FLT_TIMEOUT;
            state <= ST_DONE;
          end else if (mem.ready) begin
            state <= ST_RESP;
          end
        end
        // Data phase for loads
        ST_RESP: begin
          cnt <= cnt_nxt;
          if (mem.rvalid) begin
            rdata <= ld_data;
            state <= ST_DONE;
          end else if (expired) begin
            fault <= FLT_TIMEOUT;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

endmodule
